// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo_out, remainder to hi_out.
// One quotient bit per clock; handshake is div_control in, div_end pulse out.
//
// state | meaning
// IDLE  | waiting for div_control, operands latched on accept
// LOAD  | record signs, form magnitudes, detect zero divisor
// RUN   | one restoring iteration per clock, WIDTH cycles
// FIX   | apply signs and publish quotient/remainder
// DONE  | last busy cycle; div_end pulses on the following cycle
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             div_control,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_end,
   output logic             div_zero,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             sign_q;
   logic             sign_r;

   // Trial subtraction carries one guard bit so its sign falls out of the MSB.
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         div_end  <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
      end else begin
         div_end <= 1'b0;
         case (state)
            IDLE: begin
               if (div_control) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  busy  <= 1'b1;
                  state <= LOAD;
               end else begin
                  busy <= 1'b0;
               end
            end
            LOAD: begin
               sign_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
               sign_r <= a_reg[WIDTH-1];
               quo    <= a_reg[WIDTH-1] ? -a_reg : a_reg;
               dvs    <= b_reg[WIDTH-1] ? -b_reg : b_reg;
               rem    <= '0;
               cnt    <= CW'(WIDTH - 1);
               if (b_reg == '0) begin
                  div_zero <= 1'b1;
                  state    <= DONE;
               end else begin
                  div_zero <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!diff[WIDTH+1]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - 1'b1;
            end
            FIX: begin
               lo_out <= sign_q ? -quo : quo;
               hi_out <= sign_r ? -rem : rem;
               state  <= DONE;
            end
            DONE: begin
               div_end <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands against
// a 64-bit arithmetic reference of truncating signed division.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        div_control;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_end;
   logic        div_zero;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .a_in       (a_in),
      .b_in       (b_in),
      .div_control(div_control),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .div_end    (div_end),
      .div_zero   (div_zero),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division done in 64 bits so -2^31/-1 is well defined.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         lo = last_lo;
         hi = last_hi;
         dz = 1'b1;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa - q * sb;
         lo = q[31:0];
         hi = r[31:0];
         dz = 1'b0;
      end
   endtask

   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] e_lo, e_hi;
      logic        e_dz;
      int          n;
      bit          seen;
      model(a, b, e_lo, e_hi, e_dz);
      @(negedge clk);
      a_in = a;
      b_in = b;
      div_control = 1'b1;
      @(posedge clk);
      #1;
      div_control = 1'b0;
      a_in = $urandom;
      b_in = $urandom;
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      n = 0;
      seen = 1'b0;
      while (n < 100 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (div_end) seen = 1'b1;
      end
      check({tag, "_latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd35);
      check({tag, "_lo"}, 64'(lo_out), 64'(e_lo));
      check({tag, "_hi"}, 64'(hi_out), 64'(e_hi));
      check({tag, "_dz"}, 64'(div_zero), 64'(e_dz));
      check({tag, "_busy_end"}, 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      check({tag, "_end_pulse"}, 64'(div_end), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy), 64'd0);
      last_lo = e_lo;
      last_hi = e_hi;
   endtask

   initial begin
      logic [31:0] ra, rb;
      int ends, end_at;

      reset = 1'b0;
      a_in = '0;
      b_in = '0;
      div_control = 1'b0;
      #12;
      check("rst_hi", 64'(hi_out), 64'd0);
      check("rst_lo", 64'(lo_out), 64'd0);
      check("rst_flags", {61'd0, div_end, div_zero, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_div(32'd100, 32'd7, "p100_7");
      do_div(-32'sd100, 32'd7, "n100_7");
      do_div(32'd100, -32'sd7, "p100_n7");
      do_div(32'd100, 32'd7, "p100_7b");
      do_div(32'd5, 32'd0, "zero_div");
      do_div(32'h8000_0000, 32'hFFFF_FFFF, "overflow");
      do_div(32'd3, 32'd10, "small");
      do_div(32'h8000_0000, 32'd1, "minint_1");

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = rb >> $urandom_range(31, 20);
         if (i % 4 == 2) rb = -32'(rb[3:0]);
         do_div(ra, rb, $sformatf("rnd%0d", i));
      end

      // Extra start requests while busy must be ignored.
      @(negedge clk);
      a_in = 32'd100;
      b_in = 32'd7;
      div_control = 1'b1;
      @(posedge clk);
      #1;
      div_control = 1'b0;
      ends = 0;
      end_at = 0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (div_end) begin
            ends++;
            end_at = k;
         end
         if (k == 5 || k == 20) begin
            div_control = 1'b1;
            a_in = 32'd50;
            b_in = 32'd3;
         end else begin
            div_control = 1'b0;
         end
      end
      check("ign_count", 64'(ends), 64'd1);
      check("ign_at", 64'(end_at), 64'd35);
      check("ign_lo", 64'(lo_out), 64'd14);
      check("ign_hi", 64'(hi_out), 64'd2);

      // Reset in the middle of a division aborts it without a done pulse.
      @(negedge clk);
      a_in = 32'd100;
      b_in = 32'd7;
      div_control = 1'b1;
      @(posedge clk);
      #1;
      div_control = 1'b0;
      repeat (17) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_hi", 64'(hi_out), 64'd0);
      check("abort_lo", 64'(lo_out), 64'd0);
      check("abort_flags", {61'd0, div_end, div_zero, busy}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      last_lo = '0;
      last_hi = '0;
      ends = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (div_end) ends++;
      end
      check("abort_no_end", 64'(ends), 64'd0);
      do_div(32'd9, 32'd2, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
